// File: rtl/core_top.sv
// Multicycle 32-bit in-order core with a one-line I$ and a one-line
// write-through D$ sharing a single line-granular miss port.
package core_pkg;
    localparam int CORE_ADDR_W = 32;
    localparam int CORE_LINE_W = 128;

    typedef struct packed {
        logic [CORE_ADDR_W-1:0] addr;      // line index (byte address >> 4)
        logic                   is_store;
        logic [CORE_LINE_W-1:0] data;
    } memory_request_t;
endpackage

module core_top
    import core_pkg::*;
#(
    parameter int                    ADDR_WIDTH = CORE_ADDR_W,
    parameter int                    LINE_WIDTH = CORE_LINE_W,
    parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = 32'h2000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] boot_addr,
    output logic                  dcache_req_valid_miss,
    output memory_request_t       dcache_req_info_miss,
    output logic                  icache_req_valid_miss,
    output memory_request_t       icache_req_info_miss,
    input  logic [LINE_WIDTH-1:0] rsp_data_miss,
    input  logic                  rsp_valid_miss,
    input  logic                  rsp_cache_id,
    input  logic                  rsp_bus_error
);

    typedef enum logic [2:0] {FETCH, IWAIT, EXEC, DWAIT, SWAIT} state_t;

    localparam int TAG_W = ADDR_WIDTH - 4;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   pc, pc_next, pc_plus4;
    logic [31:0]             rf [16];
    logic [31:0]             ir;
    logic [LINE_WIDTH-1:0]   iline, dline, merged;
    logic [TAG_W-1:0]        itag, dtag;
    logic                    ivalid, dvalid;

    // Decoded instruction fields and operands
    logic [3:0]  op, rd, ra, rb;
    logic [31:0] imm, va, vb, vd, ea, iword, dword, rf_wd;
    logic        ihit, dhit, rsp_i, rsp_d;
    logic        rf_we, ir_ld, i_fill, d_fill, d_upd, ireq, dreq, dreq_st;
    logic        unused_bits;

    assign op  = ir[31:28];
    assign rd  = ir[27:24];
    assign ra  = ir[23:20];
    assign rb  = ir[19:16];
    assign imm = {{16{ir[15]}}, ir[15:0]};
    assign va  = (ra == 4'd0) ? 32'd0 : rf[ra];
    assign vb  = (rb == 4'd0) ? 32'd0 : rf[rb];
    assign vd  = (rd == 4'd0) ? 32'd0 : rf[rd];
    assign ea  = va + imm;

    assign pc_plus4 = pc + 32'd4;
    assign ihit     = ivalid && (itag == pc[ADDR_WIDTH-1:4]);
    assign iword    = iline[{pc[3:2], 5'd0} +: 32];
    assign dhit     = dvalid && (dtag == ea[ADDR_WIDTH-1:4]);
    assign dword    = dline[{ea[3:2], 5'd0} +: 32];

    // A response only counts for the cache whose id it carries
    assign rsp_i = rsp_valid_miss && !rsp_cache_id;
    assign rsp_d = rsp_valid_miss &&  rsp_cache_id;

    assign unused_bits = ^ea[1:0];

    // Store data: cached line with the addressed word replaced by rd
    always_comb begin
        merged = dline;
        merged[{ea[3:2], 5'd0} +: 32] = vd;
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) state <= FETCH;
        else        state <= state_next;
    end

    // Next-state and datapath control
    always_comb begin
        state_next = state;
        pc_next    = pc;
        rf_we      = 1'b0;
        rf_wd      = '0;
        ir_ld      = 1'b0;
        i_fill     = 1'b0;
        d_fill     = 1'b0;
        d_upd      = 1'b0;
        ireq       = 1'b0;
        dreq       = 1'b0;
        dreq_st    = 1'b0;
        case (state)
            FETCH: begin
                if (ihit) begin
                    ir_ld      = 1'b1;
                    state_next = EXEC;
                end else begin
                    ireq       = 1'b1;
                    state_next = IWAIT;
                end
            end
            IWAIT: begin
                if (rsp_i) begin
                    state_next = FETCH;
                    if (rsp_bus_error) pc_next = EXC_VECTOR;
                    else               i_fill  = 1'b1;
                end
            end
            EXEC: begin
                state_next = FETCH;
                pc_next    = pc_plus4;
                case (op)
                    4'd0: begin rf_we = 1'b1; rf_wd = va + vb;  end
                    4'd1: begin rf_we = 1'b1; rf_wd = va - vb;  end
                    4'd2: begin rf_we = 1'b1; rf_wd = va + imm; end
                    4'd3, 4'd4: begin
                        if (!dhit) begin
                            // Fill first, then retry the same instruction
                            pc_next    = pc;
                            dreq       = 1'b1;
                            state_next = DWAIT;
                        end else if (op == 4'd3) begin
                            rf_we = 1'b1;
                            rf_wd = dword;
                        end else begin
                            // PC advances only once the write-through is acked
                            pc_next    = pc;
                            dreq       = 1'b1;
                            dreq_st    = 1'b1;
                            state_next = SWAIT;
                        end
                    end
                    4'd5: if (vd == va) pc_next = pc + (imm << 2);
                    4'd6: pc_next = va + imm;
                    default: ;
                endcase
            end
            DWAIT: begin
                if (rsp_d) begin
                    if (rsp_bus_error) begin
                        pc_next    = EXC_VECTOR;
                        state_next = FETCH;
                    end else begin
                        d_fill     = 1'b1;
                        state_next = EXEC;
                    end
                end
            end
            SWAIT: begin
                if (rsp_d) begin
                    state_next = FETCH;
                    if (rsp_bus_error) begin
                        pc_next = EXC_VECTOR;
                    end else begin
                        pc_next = pc_plus4;
                        d_upd   = 1'b1;
                    end
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // Architectural state, cache valids and the registered request port
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc                    <= boot_addr;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
            ivalid                <= 1'b0;
            dvalid                <= 1'b0;
            icache_req_valid_miss <= 1'b0;
            dcache_req_valid_miss <= 1'b0;
            icache_req_info_miss  <= '0;
            dcache_req_info_miss  <= '0;
        end else begin
            pc <= pc_next;
            if (rf_we && rd != 4'd0) rf[rd] <= rf_wd;
            if (i_fill) ivalid <= 1'b1;
            if (d_fill) dvalid <= 1'b1;
            icache_req_valid_miss <= ireq;
            dcache_req_valid_miss <= dreq;
            if (ireq) begin
                icache_req_info_miss.addr     <= {4'd0, pc[ADDR_WIDTH-1:4]};
                icache_req_info_miss.is_store <= 1'b0;
                icache_req_info_miss.data     <= '0;
            end
            if (dreq) begin
                dcache_req_info_miss.addr     <= {4'd0, ea[ADDR_WIDTH-1:4]};
                dcache_req_info_miss.is_store <= dreq_st;
                dcache_req_info_miss.data     <= dreq_st ? merged : '0;
            end
        end
    end

    // Cache payloads and the instruction register (qualified by valid bits)
    always_ff @(posedge clock) begin
        if (ir_ld) ir <= iword;
        if (i_fill) begin
            iline <= rsp_data_miss;
            itag  <= pc[ADDR_WIDTH-1:4];
        end
        if (d_fill) begin
            dline <= rsp_data_miss;
            dtag  <= ea[ADDR_WIDTH-1:4];
        end else if (d_upd) begin
            dline <= dcache_req_info_miss.data;
        end
    end

endmodule

// File: tb/tb_core_top.sv
// Scoreboard bench: a line memory model answers the miss port, expected
// requests are queued per program phase and compared as the core issues them.
module tb_core_top;
    import core_pkg::*;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [31:0]     boot_addr;
    logic            dcache_req_valid_miss, icache_req_valid_miss;
    memory_request_t dcache_req_info_miss, icache_req_info_miss;
    logic [127:0]    rsp_data_miss;
    logic            rsp_valid_miss, rsp_cache_id, rsp_bus_error;

    core_top dut (
        .clock                 (clock),
        .reset                 (reset),
        .boot_addr             (boot_addr),
        .dcache_req_valid_miss (dcache_req_valid_miss),
        .dcache_req_info_miss  (dcache_req_info_miss),
        .icache_req_valid_miss (icache_req_valid_miss),
        .icache_req_info_miss  (icache_req_info_miss),
        .rsp_data_miss         (rsp_data_miss),
        .rsp_valid_miss        (rsp_valid_miss),
        .rsp_cache_id          (rsp_cache_id),
        .rsp_bus_error         (rsp_bus_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit           dc;
        logic [31:0]  addr;
        bit           st;
        logic [127:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] mem [logic [31:0]];
    int           checks = 0;
    int           failures = 0;

    localparam logic [31:0] NOP = 32'hFFFF_FFFF;
    localparam logic [127:0] JUNK = {4{32'hDEAD_BEEF}};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] ra, input logic [3:0] rb,
                                        input logic [15:0] imm);
        return {op, rd, ra, rb, imm};
    endfunction

    task automatic push(input bit dc, input logic [31:0] addr, input bit st, input logic [127:0] data);
        exp_t e;
        e.dc = dc; e.addr = addr; e.st = st; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic idle_rsp();
        rsp_valid_miss = 1'b0;
        rsp_cache_id   = 1'b0;
        rsp_bus_error  = 1'b0;
        rsp_data_miss  = '0;
    endtask

    // Called on a negedge: wait for the next request, score it, then answer
    // (optionally preceded by a response tagged for the other cache).
    task automatic serve(input bit err, input bit spur, input bit spur_err, input bit respond);
        exp_t            e;
        memory_request_t info;
        bit              seen;
        int              n = 0;
        seen = icache_req_valid_miss | dcache_req_valid_miss;
        while (!seen && n < 400) begin
            @(negedge clock);
            seen = icache_req_valid_miss | dcache_req_valid_miss;
            n++;
        end
        chk("req_seen", seen, 1);
        if (!seen) return;
        chk("req_queue_empty", exp_q.size() == 0, 0);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        chk("req_both", icache_req_valid_miss & dcache_req_valid_miss, 0);
        chk("req_src", dcache_req_valid_miss, e.dc);
        info = e.dc ? dcache_req_info_miss : icache_req_info_miss;
        chk("req_addr", info.addr, e.addr);
        chk("req_store", info.is_store, e.st);
        if (e.st || !e.dc) chk("req_data", info.data, e.data);
        if (e.st) mem[e.addr] = e.data;
        @(negedge clock);
        chk("req_pulse", icache_req_valid_miss | dcache_req_valid_miss, 0);
        if (spur) begin
            rsp_valid_miss = 1'b1;
            rsp_cache_id   = ~e.dc;
            rsp_bus_error  = spur_err;
            rsp_data_miss  = JUNK;
            @(negedge clock);
            idle_rsp();
        end
        if (respond) begin
            rsp_valid_miss = 1'b1;
            rsp_cache_id   = e.dc;
            rsp_bus_error  = err;
            rsp_data_miss  = mem.exists(e.addr) ? mem[e.addr] : '0;
            @(negedge clock);
            idle_rsp();
        end
    endtask

    logic [127:0] l300, st300, l004, s1, s2, s3, s4;
    int           cnt;

    initial begin
        idle_rsp();
        boot_addr = 32'h1000;

        mem[32'h100] = {NOP, NOP, NOP, enc(2, 1, 0, 0, 16'd5)};
        mem[32'h101] = {enc(3, 4, 2, 0, 16'd4), enc(4, 3, 2, 0, 16'd4),
                        enc(2, 3, 0, 0, 16'd7), enc(2, 2, 0, 0, 16'h3000)};
        mem[32'h102] = {enc(6, 0, 2, 0, 16'd0), enc(5, 0, 0, 0, 16'hFFFE),
                        enc(5, 5, 1, 0, 16'd2), enc(2, 5, 5, 0, 16'd1)};
        l300         = {enc(0, 7, 6, 1, 16'd0), enc(1, 6, 1, 3, 16'd0),
                        32'hFAAA_0001, 32'hFAAA_0000};
        mem[32'h300] = l300;
        mem[32'h301] = {4{NOP}};
        mem[32'h200] = {enc(4, 7, 0, 0, 16'h4C), enc(4, 5, 0, 0, 16'h48),
                        enc(4, 1, 0, 0, 16'h44), enc(4, 4, 0, 0, 16'h40)};
        mem[32'h201] = {4{NOP}};
        l004         = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        mem[32'h004] = l004;

        // Expected write-through images (r4=7, r1=5, r5=5, r7=5+(5-7)=3)
        st300 = l300;  st300[63:32]  = 32'd7;
        s1    = l004;  s1[31:0]      = 32'd7;
        s2    = s1;    s2[63:32]     = 32'd5;
        s3    = s2;    s3[95:64]     = 32'd5;
        s4    = s3;    s4[127:96]    = 32'd3;

        repeat (3) @(negedge clock);
        chk("rst_ivalid", icache_req_valid_miss, 0);
        chk("rst_dvalid", dcache_req_valid_miss, 0);
        chk("rst_iinfo", icache_req_info_miss.addr, 0);
        chk("rst_dinfo_addr", dcache_req_info_miss.addr, 0);
        chk("rst_dinfo_data", dcache_req_info_miss.data, 0);
        chk("rst_dinfo_st", dcache_req_info_miss.is_store, 0);
        reset = 1'b1;

        // Boot fetch, ADDI commit two cycles after the fill, then NOPs hit
        push(0, 32'h100, 0, '0);
        serve(0, 0, 0, 1);
        repeat (2) @(posedge clock);
        #1 chk("r1_addi", dut.rf[1], 5);
        cnt = 0;
        repeat (6) begin
            @(negedge clock);
            if (icache_req_valid_miss | dcache_req_valid_miss) cnt++;
        end
        chk("ihit_no_req", cnt, 0);

        push(0, 32'h101, 0, '0);
        push(1, 32'h300, 0, '0);
        push(1, 32'h300, 1, st300);
        push(0, 32'h102, 0, '0);
        push(0, 32'h300, 0, '0);
        push(0, 32'h301, 0, '0);
        push(0, 32'h200, 0, '0);
        push(1, 32'h004, 0, '0);
        push(1, 32'h004, 1, s1);
        push(1, 32'h004, 1, s2);
        push(1, 32'h004, 1, s3);
        push(1, 32'h004, 1, s4);
        push(0, 32'h201, 0, '0);

        serve(0, 1, 0, 1);            // I$ fill, stray D$-tagged response first
        serve(0, 1, 1, 1);            // D$ load, stray I$ error response first
        serve(0, 0, 0, 1);            // write-through of r3
        repeat (2) @(posedge clock);
        #1 chk("r4_ldw_hit", dut.rf[4], 7);
        @(negedge clock);
        serve(0, 0, 0, 1);            // branch loop line
        serve(0, 1, 1, 1);            // JMP target line 0x300
        serve(1, 0, 0, 1);            // fill with bus error -> vector
        serve(0, 0, 0, 1);            // vector line
        serve(0, 0, 0, 1);            // D$ miss on 0x40
        serve(0, 0, 0, 1);
        serve(0, 0, 0, 1);
        serve(0, 0, 0, 1);
        serve(0, 0, 0, 1);
        serve(0, 0, 0, 0);            // I$ miss left outstanding
        chk("queue_drained", exp_q.size(), 0);

        // Reset mid-request; a late response in the first FETCH is dropped
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst2_r1", dut.rf[1], 0);
        chk("rst2_r2", dut.rf[2], 0);
        chk("rst2_ivalid", icache_req_valid_miss, 0);
        chk("rst2_dinfo", dcache_req_info_miss.data, 0);
        push(0, 32'h100, 0, '0);
        reset          = 1'b1;
        rsp_valid_miss = 1'b1;
        rsp_cache_id   = 1'b0;
        rsp_data_miss  = JUNK;
        @(negedge clock);
        idle_rsp();
        serve(0, 0, 0, 1);
        repeat (2) @(posedge clock);
        #1 chk("r1_after_reset", dut.rf[1], 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_top.md
Name: core_top

Overview:
- Minimal multicycle 32-bit in-order core.
- Has a one-line instruction cache (I$) and a one-line write-through data cache (D$).
- Both caches share one line-granular miss interface to the memory arbiter in the SoC/testbench.
- Executes from boot_addr until the environment stops it; an all-ones instruction word is a NOP.

Parameters:
ADDR_WIDTH, 32, byte address and request address width
LINE_WIDTH, 128, cache line width in bits (= DCACHE_LINE_WIDTH = ICACHE_LINE_WIDTH); 4 words per line
EXC_VECTOR, 32'h2000, PC loaded on a memory bus error

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-low reset
boot_addr  in  ADDR_WIDTH  initial PC, sampled while reset is asserted
dcache_req_valid_miss  out  1  one-cycle pulse: D$ request to memory
dcache_req_info_miss  out  memory_request_t  D$ request fields: addr[ADDR_WIDTH] = line index (byte addr >> 4), is_store[1], data[LINE_WIDTH]
icache_req_valid_miss  out  1  one-cycle pulse: I$ line fill request
icache_req_info_miss  out  memory_request_t  I$ request; is_store always 0, data always 0
rsp_data_miss  in  LINE_WIDTH  returned line
rsp_valid_miss  in  1  response strobe, one cycle
rsp_cache_id  in  1  0 = response for I$, 1 = response for D$
rsp_bus_error  in  1  qualifies rsp_valid_miss as an address error

Behaviour:
- Reset (reset==0 at a clock edge):
  - PC <= boot_addr; r0..r15 <= 0.
  - Both cache valid bits <= 0; FSM <= FETCH.
  - Both req_valid outputs 0; both info outputs all-zero.
- Instruction format, 32 bits:
  - op[31:28], rd[27:24], ra[23:20], rb[19:16], imm[15:0] (sign-extended).
  - r0 reads 0; writes to r0 are discarded.
- Opcodes:
  - 0 ADD: rd = ra + rb.
  - 1 SUB: rd = ra - rb.
  - 2 ADDI: rd = ra + imm.
  - 3 LDW: rd = M[ra + imm].
  - 4 STW: M[ra + imm] = rd.
  - 5 BEQ: if rd == ra, PC = PC + (imm << 2).
  - 6 JMP: PC = ra + imm.
  - All other opcodes (including 32'hFFFFFFFF): NOP.
  - Arithmetic is 32-bit modulo 2^32.
  - PC advances by 4 unless a taken branch or jump updates it.
- Addressing: word offset within a line = addr[3:2]; addr[1:0] ignored; word k = line bits [32k+31:32k]; line tag = addr >> 4.
- Request rules:
  - Assert req_valid for exactly one cycle; info is valid in that cycle and held until the next request.
  - At most one outstanding request in total; I$ and D$ never overlap.
- Response rules:
  - Accept a response only in the matching WAIT state, with rsp_valid_miss=1 and the matching rsp_cache_id.
  - Ignore all other responses.
- FSM states: FETCH, IWAIT, EXEC, DWAIT, SWAIT.
- FETCH:
  - I$ hit (valid and tag == PC>>4): latch the instruction, go to EXEC.
  - Miss: pulse icache request with addr = PC>>4, go to IWAIT.
- IWAIT:
  - Accepted response, no error: I$ line <= rsp_data_miss, tag <= PC>>4, valid <= 1, go to FETCH.
- EXEC:
  - ALU, branch, jump or NOP: commit, go to FETCH.
  - Every instruction takes at least 2 cycles.
  - LDW/STW on D$ miss: pulse D$ load request (is_store=0, addr = EA>>4), go to DWAIT.
  - LDW on D$ hit: write rd from the line word, PC += 4, go to FETCH.
  - STW on D$ hit: merge rd into the cached line; pulse D$ request with is_store=1, addr = EA>>4, data = merged line; go to SWAIT.
- DWAIT: accepted response fills the D$ line; return to EXEC to retry the instruction (now a hit).
- SWAIT: accepted response: PC += 4, go to FETCH (write-through completes).
- Bus error: if rsp_bus_error=1 on an accepted response:
  - No fill; the instruction is not committed.
  - PC <= EXC_VECTOR, go to FETCH.
- Stores do not update or invalidate the I$; there is no coherence with self-modifying code.
- Reset asserted mid-request abandons all state; late responses after reset are ignored (FSM is in FETCH).

Test Plan:
- boot_addr=0x1000, memory line 0x100 = {NOP,NOP,NOP,ADDI r1,r0,5} → exactly one icache pulse with addr=0x100; after 2 more cycles r1=5; the next 3 fetches hit with no further requests.
- Sequence ADDI r2,r0,0x3000; ADDI r3,r0,7; STW r3,[r2+4] → D$ load request addr=0x300, then store request addr=0x300, is_store=1, data bits[63:32]=7 with the rest preserved from the fill.
- LDW r4,[r2+4] after that store → D$ hit, no request; r4=7 two cycles later.
- BEQ r0,r0,-2 → PC returns to the branch address minus 8; JMP r2,0 → PC=0x3000, triggering an I$ miss with addr=0x300.
- A fill response returned with rsp_bus_error=1 → no register change; next icache request addr=0x200 (EXC_VECTOR>>4).
- Spurious responses: rsp_valid_miss with cache_id=1 while in IWAIT, or any response in EXEC → ignored; the state is unchanged.
